// File: rtl/seq_frame_decoder_pkg.sv
// ---------------------------------------------------------------------------
// seq_frame_decoder_pkg
//   Shared definitions for the serial frame decoder and for any bench that
//   drives or generates the same frame format.
//     state_e    : decoder FSM states (IDLE, RECV)
//     FRAME_PAT  : default frame, first transmitted bit is the MSB
//     FRAME_LEN  : default frame length in bits
// ---------------------------------------------------------------------------
package seq_frame_decoder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_e;

   localparam int unsigned FRAME_LEN = 6;
   localparam logic [FRAME_LEN-1:0] FRAME_PAT = 6'b100011;

endpackage : seq_frame_decoder_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that holds at all-ones instead of wrapping.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous active-low reset, clears count
//     inc   : increment request for this edge
//     clr   : synchronous clear, wins over inc
//     count : registered count value
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/seq_frame_decoder.sv
// ---------------------------------------------------------------------------
// seq_frame_decoder
//   Serial receiver for the fixed frame emitted by the triggered sequence
//   generator. One bit is sampled per clock; a correct frame yields a
//   one-cycle frame_ok pulse, a mismatching bit yields a one-cycle frame_err
//   pulse. Good and bad frames are counted with saturating counters.
//   Ports:
//     clk       : rising-edge clock
//     reset     : asynchronous active-low reset
//     din       : serial frame bit (synchronous to clk)
//     clr       : synchronous clear of ok_cnt / err_cnt
//     frame_ok  : registered pulse, complete correct frame received
//     frame_err : registered pulse, frame aborted by a mismatching bit
//     busy      : registered, high while a frame is in progress
//     ok_cnt    : saturating good-frame count
//     err_cnt   : saturating bad-frame count
// ---------------------------------------------------------------------------
module seq_frame_decoder
   import seq_frame_decoder_pkg::*;
#(
   parameter int unsigned        PAT_LEN = FRAME_LEN,
   parameter logic [PAT_LEN-1:0] PAT     = FRAME_PAT,
   parameter int unsigned        CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             clr,
   output logic             frame_ok,
   output logic             frame_err,
   output logic             busy,
   output logic [CNT_W-1:0] ok_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned IDX_W = $clog2(PAT_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);
   localparam logic [PAT_LEN-1:0] MSB_MASK = {1'b1, {(PAT_LEN-1){1'b0}}};

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             ok_q, ok_d;
   logic             err_q, err_d;
   logic             exp_bit;

   // Expected bit for position idx is PAT[PAT_LEN-1-idx]; selecting it with a
   // shifted MSB mask keeps every PAT bit in use and avoids a reversed index.
   assign exp_bit = |(PAT & (MSB_MASK >> idx_q));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (din) begin
               state_d = RECV;
               idx_d   = IDX_W'(1);
               busy_d  = 1'b1;
            end
         end
         RECV: begin
            if (din == exp_bit) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  busy_d  = 1'b0;
                  ok_d    = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               err_d = 1'b1;
               // A mismatching 1 doubles as the start bit of the next frame.
               if (din) begin
                  idx_d = IDX_W'(1);
               end else begin
                  state_d = IDLE;
                  idx_d   = '0;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
   end

   // Counters advance on the same edge that registers the pulse.
   sat_counter #(.W(CNT_W)) u_ok_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ok_d),
      .clr   (clr),
      .count (ok_cnt)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_d),
      .clr   (clr),
      .count (err_cnt)
   );

   assign frame_ok  = ok_q;
   assign frame_err = err_q;
   assign busy      = busy_q;

endmodule : seq_frame_decoder

// File: tb/tb_seq_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_seq_frame_decoder
//   Bench for seq_frame_decoder. Two instances share din/clr/reset: one with
//   8-bit counters, one with 2-bit counters. Expected outputs come from a
//   frame-level model that keeps the bits of the frame in progress in a queue.
//   A small behavioural generator can drive din instead of the bench.
// ---------------------------------------------------------------------------
module tb_seq_frame_decoder;

   localparam int unsigned PLEN = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       din;
   logic       din_drv;
   logic       clr;
   logic       gen_trig;
   logic       gen_en;
   logic       gen_out;
   logic [5:0] gen_sh;
   int         gen_cnt;
   logic [5:0] pat_v;

   logic       ok_a, err_a, busy_a;
   logic [7:0] okc_a, errc_a;
   logic       ok_b, err_b, busy_b;
   logic [1:0] okc_b, errc_b;
   logic [25:0] obs;

   int n_vec = 0;
   int n_err = 0;
   int edge_no = 0;

   // reference model state
   bit   mq[$];
   logic m_ok, m_err, m_busy;
   int   m_oc[2];
   int   m_ec[2];

   always #5 clk = ~clk;

   seq_frame_decoder dut_a (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .clr       (clr),
      .frame_ok  (ok_a),
      .frame_err (err_a),
      .busy      (busy_a),
      .ok_cnt    (okc_a),
      .err_cnt   (errc_a)
   );

   seq_frame_decoder #(.CNT_W(2)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .clr       (clr),
      .frame_ok  (ok_b),
      .frame_err (err_b),
      .busy      (busy_b),
      .ok_cnt    (okc_b),
      .err_cnt   (errc_b)
   );

   assign obs = {ok_a, err_a, busy_a, okc_a, errc_a, ok_b, err_b, busy_b, okc_b, errc_b};

   // behavioural trigger-driven generator: emits the frame MSB first after
   // sampling gen_trig high while idle
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         gen_cnt <= 0;
         gen_sh  <= '0;
      end else if (gen_cnt == 0) begin
         if (gen_trig) begin
            gen_sh  <= pat_v;
            gen_cnt <= 6;
         end
      end else begin
         gen_sh  <= gen_sh << 1;
         gen_cnt <= gen_cnt - 1;
      end
   end
   assign gen_out = (gen_cnt != 0) && gen_sh[5];
   assign din     = gen_en ? gen_out : din_drv;

   function automatic logic [25:0] exp_vec();
      return {m_ok, m_err, m_busy, 8'(m_oc[0]), 8'(m_ec[0]),
              m_ok, m_err, m_busy, 2'(m_oc[1]), 2'(m_ec[1])};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ok = 0; m_err = 0; m_busy = 0;
      for (int i = 0; i < 2; i++) begin m_oc[i] = 0; m_ec[i] = 0; end
   endtask

   task automatic model_step(input logic b, input logic c);
      logic e;
      int   lim;
      m_ok  = 0;
      m_err = 0;
      if (mq.size() == 0) begin
         if (b) mq.push_back(1'b1);
      end else begin
         e = pat_v[PLEN - 1 - mq.size()];
         if (b == e) begin
            mq.push_back(b);
            if (mq.size() == PLEN) begin
               m_ok = 1;
               mq.delete();
            end
         end else begin
            m_err = 1;
            mq.delete();
            if (b) mq.push_back(1'b1);
         end
      end
      m_busy = (mq.size() != 0);
      for (int i = 0; i < 2; i++) begin
         lim = (i == 0) ? 255 : 3;
         if (c) begin
            m_oc[i] = 0; m_ec[i] = 0;
         end else begin
            if (m_ok  && m_oc[i] < lim) m_oc[i]++;
            if (m_err && m_ec[i] < lim) m_ec[i]++;
         end
      end
   endtask

   task automatic step(input logic b, input logic c, input logic t);
      logic bs;
      @(negedge clk);
      din_drv  = b;
      clr      = c;
      gen_trig = t;
      #1 bs = din;
      @(posedge clk);
      #1;
      model_step(bs, c);
      edge_no++;
   endtask

   task automatic test_reset();
      reset = 0; din_drv = 0; clr = 0; gen_trig = 0; gen_en = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (obs !== 26'b0) begin
         n_err++;
         $display("FAIL reset_hold: got %h expected %h", obs, 26'b0);
      end
      @(negedge clk) reset = 1;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0);
         n_vec++;
         if (obs !== exp_vec() || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL idle_zero step %0d: got %h expected %h", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_single_frame();
      logic [6:0] bits = 7'b1000110;
      logic       exp_busy, exp_ok;
      for (int i = 0; i < 7; i++) begin
         step(bits[6-i], 0, 0);
         exp_busy = (i <= 4);
         exp_ok   = (i == 5);
         n_vec++;
         if (obs !== exp_vec() || busy_a !== exp_busy || ok_a !== exp_ok) begin
            n_err++;
            $display("FAIL single_frame step %0d: got %h busy %b ok %b expected %h busy %b ok %b",
                     i, obs, busy_a, ok_a, exp_vec(), exp_busy, exp_ok);
         end
      end
      n_vec++;
      if (okc_a !== 8'd1 || errc_a !== 8'd0) begin
         n_err++;
         $display("FAIL single_frame_counts: got ok %0d err %0d expected ok 1 err 0", okc_a, errc_a);
      end
   endtask

   task automatic test_generator();
      int trig_edge;
      int pulses = 0;
      step(0, 1, 0);
      gen_en = 1;
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 1);
         trig_edge = edge_no;
         for (int j = 0; j < 8; j++) begin
            step(0, 0, 0);
            n_vec++;
            if (obs !== exp_vec() || (ok_a === 1'b1) !== (edge_no - trig_edge == 6)) begin
               n_err++;
               $display("FAIL generator trig %0d +%0d: got %h ok %b expected %h ok at +6",
                        k, edge_no - trig_edge, obs, ok_a, exp_vec());
            end
            if (ok_a === 1'b1) pulses++;
         end
      end
      gen_en = 0;
      n_vec++;
      if (pulses != 3 || okc_a !== 8'd3) begin
         n_err++;
         $display("FAIL generator_count: got pulses %0d ok_cnt %0d expected 3 and 3", pulses, okc_a);
      end
   endtask

   task automatic test_mismatch_restart();
      logic [7:0] bits = 8'b10100011;
      step(0, 1, 0);
      for (int i = 0; i < 8; i++) begin
         step(bits[7-i], 0, 0);
         n_vec++;
         if (obs !== exp_vec() || err_a !== (i == 2) || ok_a !== (i == 7)) begin
            n_err++;
            $display("FAIL mismatch_restart step %0d: got %h err %b ok %b expected %h",
                     i, obs, err_a, ok_a, exp_vec());
         end
      end
      n_vec++;
      if (okc_a !== 8'd1 || errc_a !== 8'd1) begin
         n_err++;
         $display("FAIL mismatch_counts: got ok %0d err %0d expected 1 and 1", okc_a, errc_a);
      end
   endtask

   task automatic test_back_to_back();
      int first_ok = -1;
      int second_ok = -1;
      step(0, 1, 0);
      for (int i = 0; i < 13; i++) begin
         step((i < 12) ? pat_v[5 - (i % 6)] : 1'b0, 0, 0);
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL back_to_back step %0d: got %h expected %h", i, obs, exp_vec());
         end
         if (ok_a === 1'b1) begin
            if (first_ok < 0) first_ok = i; else second_ok = i;
         end
      end
      n_vec++;
      if (first_ok != 5 || second_ok != 11) begin
         n_err++;
         $display("FAIL back_to_back_spacing: got ok at %0d and %0d expected 5 and 11", first_ok, second_ok);
      end
   endtask

   task automatic test_saturation();
      logic c;
      step(0, 1, 0);
      for (int f = 0; f < 5; f++) begin
         for (int k = 0; k < 6; k++) begin
            c = (f == 4 && k == 5);
            step(pat_v[5 - k], c, 0);
            n_vec++;
            if (obs !== exp_vec()) begin
               n_err++;
               $display("FAIL saturation f%0d b%0d: got %h expected %h", f, k, obs, exp_vec());
            end
         end
         if (f == 3) begin
            n_vec++;
            if (okc_b !== 2'd3 || okc_a !== 8'd4) begin
               n_err++;
               $display("FAIL saturate_hold: got b %0d a %0d expected 3 and 4", okc_b, okc_a);
            end
         end
      end
      n_vec++;
      if (okc_b !== 2'd0 || okc_a !== 8'd0 || ok_b !== 1'b1) begin
         n_err++;
         $display("FAIL clr_wins: got b %0d a %0d ok %b expected 0 0 1", okc_b, okc_a, ok_b);
      end
   endtask

   task automatic test_random();
      int   r;
      int   flip;
      logic b;
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 3);
         if (r == 0) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), 0);
            n_vec++;
            if (obs !== exp_vec()) begin
               n_err++;
               $display("FAIL random_bit %0d: got %h expected %h", n, obs, exp_vec());
            end
         end else begin
            flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : -1;
            for (int k = 0; k < 6; k++) begin
               b = pat_v[5 - k];
               if (k == flip) b = ~b;
               step(b, ($urandom_range(0, 39) == 0), 0);
               n_vec++;
               if (obs !== exp_vec() || (ok_a && err_a)) begin
                  n_err++;
                  $display("FAIL random_frame %0d b%0d: got %h expected %h", n, k, obs, exp_vec());
               end
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      @(negedge clk);
      reset = 0;
      #1;
      model_reset();
      n_vec++;
      if (obs !== 26'b0) begin
         n_err++;
         $display("FAIL midframe_reset: got %h expected %h", obs, 26'b0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0);
         n_vec++;
         if (obs !== exp_vec() || ok_a !== 1'b0 || err_a !== 1'b0) begin
            n_err++;
            $display("FAIL after_midframe_reset %0d: got %h expected %h", i, obs, exp_vec());
         end
      end
   endtask

   initial begin
      pat_v = 6'b100011;
      test_reset();
      test_single_frame();
      test_generator();
      test_mismatch_restart();
      test_back_to_back();
      test_saturation();
      test_random();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_seq_frame_decoder
